i2s_transmitter: RTL and testbench
==================================

# i2s_transmitter

Consumes signed PCM samples from an audio source (e.g. the sinusoid generator) over a valid/ready stream and serializes them as a standard Philips I2S frame toward an external DAC. Each accepted mono sample is sent on both left and right channels. The block generates its own bit clock (`bclk_o`) and word-select (`lrclk_o`) from the system clock. Its `ready_o` therefore sets the sample rate of the upstream generator: one sample per frame.

## Interface
- `width_p`, 12: sample width, two's complement.
- `slot_bits_p`, 16: bits per channel slot. Must be ≥ `width_p`.
- `bclk_div_p`, 4: system clocks per `bclk_o` half-period. Must be ≥ 1.

Ports:
- `clk_i` in 1: system clock. There is one clock; all logic is on its rising edge.
- `reset_i` in 1: reset, asynchronous, active-high.
- `data_i` in `width_p`: sample data.
- `valid_i` in 1: `data_i` is valid.
- `ready_o` out 1: holding register is empty, so the block can accept a sample.
- `bclk_o` out 1: I2S bit clock.
- `lrclk_o` out 1: word select. 0 = left, 1 = right.
- `sdata_o` out 1: serial data, MSB first.
- `underrun_o` out 1: one-cycle pulse when a frame starts and no new sample is available.

## Operation
- Reset values: `bclk_o`=0, `lrclk_o`=1, `sdata_o`=0, `underrun_o`=0, `ready_o`=1.
  - Internal divider = 0, bit index k = 2·S−1 (S = `slot_bits_p`).
  - Holding register is empty. Frame register and last-sample register are 0.
- **Handshake**
  - A sample is captured when `valid_i & ready_o` on a clock edge. The holding register then becomes full.
  - `ready_o` is `~full`, driven from a register. There is no combinational path from `valid_i`.
  - `data_i` is ignored when no capture occurs.
- **Bit clock**
  - The divider counts 0..`bclk_div_p`−1. At terminal count it wraps and `bclk_o` toggles.
  - A toggle 1→0 is a "fall event". All of `lrclk_o`, `sdata_o`, k and the frame load update only on fall events.
  - The DAC samples on the `bclk_o` rise.
- **Fall event**
  - k ← (k+1) mod 2S.
  - `lrclk_o` ← (k ≥ S).
  - `sdata_o` ← frame bit for position (k−1) mod 2S. This gives the standard one-bclk I2S delay: the last right-slot bit goes out at k=0.
- **Frame word** (2S bits)
  - Left slot is the sample MSB-first in bits 0..`width_p`−1 of the slot, then zero-padded to S bits.
  - Right slot is identical.
- **Frame load** (on the fall event where k becomes 1, before `sdata_o` is driven with position 0)
  - If the holding register is full: frame ← sample, last-sample ← sample, holding cleared. `ready_o` rises on the next cycle.
  - If the holding register is empty: frame ← last-sample (the previous sample repeats), and `underrun_o` pulses for exactly that cycle.
- **Capture and load on the same edge:** the load takes the old content and the holding register is empty afterwards. This cannot coincide with a capture, because `ready_o` was 0.
- **Reset mid-frame:** all state returns to reset values immediately. The partially sent frame is abandoned and the pending sample is discarded.

## Timing
Counting clk cycles after reset deasserts (cycle 0 = first edge), with D = `bclk_div_p` and S = `slot_bits_p`:
- `bclk_o` period is 2D. The first rise is at cycle D−1 and the first fall event is at cycle 2D−1.
- At the first fall event, k=0: `lrclk_o`=0 and `sdata_o`=0.
- At the second fall event (cycle 4D−1), k=1: first frame load, and `sdata_o` = sample MSB.
- Frame period is 4·S·D clocks, which is 256 with the defaults.
- At most one sample is accepted per frame. Throughput is exactly one sample per 256 clocks at defaults.
- Latency from capture to the MSB on `sdata_o` is up to one frame plus 4D cycles.

## Test plan
- **Basic frame** (defaults, `valid_i`=1 from reset with `data_i`=12'hA5C):
  - `lrclk_o` is low for 16 bclks.
  - Bits sampled on bclk rises for k=1..12 read 1010_0101_1100, then four 0s.
  - The right slot repeats the same pattern.
- **Handshake**
  - The first capture is at cycle 0.
  - `ready_o` is 0 until the cycle after the load at 4D−1=15, i.e. 1 at cycle 16.
  - Steady state is exactly one accept per 256 cycles.
- **Underrun:** `valid_i`=0 after the first sample.
  - `underrun_o` pulses once per frame, aligned with each k=1 fall event.
  - The serial data repeats 12'hA5C.
  - Before any sample is accepted, an underrun sends zeros.
- **Negative/extreme values:** samples 12'h800 and 12'h7FF.
  - The MSB is the first bit of each slot.
  - Verify the I2S delay: the right-slot last bit (position 31) appears at the k=0 fall event.
- **Reset mid-frame:** assert `reset_i` asynchronously at k=20, between clock edges.
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - After release, timing restarts exactly as in the Timing section.
- **Parameter sweep** (`bclk_div_p`=1, `slot_bits_p`=`width_p`=12):
  - `bclk_o` toggles every cycle.
  - Frame period is 48 cycles.
  - There are no padding bits.

Source files
------------

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: Philips I2S serializer with one-deep holding register and self-generated bclk/lrclk.
module i2s_transmitter #(
    parameter int width_p     = 12,
    parameter int slot_bits_p = 16,
    parameter int bclk_div_p  = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               bclk_o,
    output logic               lrclk_o,
    output logic               sdata_o,
    output logic               underrun_o
);
    localparam int frame_bits = 2 * slot_bits_p;
    localparam int kw = $clog2(frame_bits);
    localparam int dw = bclk_div_p > 1 ? $clog2(bclk_div_p) : 1;

    logic [dw-1:0]      div;
    logic [kw-1:0]      k, k_next, q;
    logic [width_p-1:0] hold, last, frame, src, sh;
    logic               tc, fall, load;

    // The bit emitted at a fall event is the frame position equal to the old k,
    // which yields the one-bclk I2S delay; positions past width_p shift out as zeros.
    always_comb begin
        tc     = div == dw'(bclk_div_p - 1);
        fall   = tc & bclk_o;
        k_next = k == kw'(frame_bits - 1) ? '0 : k + 1'b1;
        load   = fall & (k_next == kw'(1));
        src    = load ? (ready_o ? last : hold) : frame;
        q      = k >= kw'(slot_bits_p) ? k - kw'(slot_bits_p) : k;
        sh     = src << q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div        <= '0;
            bclk_o     <= 1'b0;
            k          <= kw'(frame_bits - 1);
            lrclk_o    <= 1'b1;
            sdata_o    <= 1'b0;
            underrun_o <= 1'b0;
            ready_o    <= 1'b1;
            hold       <= '0;
            last       <= '0;
            frame      <= '0;
        end else begin
            div        <= tc ? '0 : div + 1'b1;
            underrun_o <= load & ready_o;
            if (tc)
                bclk_o <= ~bclk_o;
            if (fall) begin
                k       <= k_next;
                lrclk_o <= k_next >= kw'(slot_bits_p);
                sdata_o <= sh[width_p-1];
            end
            if (load)
                frame <= src;
            if (load && !ready_o) begin
                last    <= hold;
                ready_o <= 1'b1;
            end else if (valid_i && ready_o) begin
                hold    <= data_i;
                ready_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: random and directed stimulus against a cycle-count based I2S reference model,
// run on a default instance (a) and a D=1, S=W=12 instance (b).
module tb_i2s_transmitter;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [W-1:0] data = '0;
    logic a_rdy, a_bclk, a_lr, a_sd, a_und;
    logic b_rdy, b_bclk, b_lr, b_sd, b_und;

    i2s_transmitter dut_a (
        .clk_i(clk), .reset_i(rst), .data_i(data), .valid_i(valid), .ready_o(a_rdy),
        .bclk_o(a_bclk), .lrclk_o(a_lr), .sdata_o(a_sd), .underrun_o(a_und)
    );

    i2s_transmitter #(.width_p(12), .slot_bits_p(12), .bclk_div_p(1)) dut_b (
        .clk_i(clk), .reset_i(rst), .data_i(data), .valid_i(valid), .ready_o(b_rdy),
        .bclk_o(b_bclk), .lrclk_o(b_lr), .sdata_o(b_sd), .underrun_o(b_und)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: everything derived from the cycle count since reset release.
    int           dv[2] = '{4, 1};
    int           sv[2] = '{16, 12};
    int           t[2];
    bit           mfull[2];
    logic [W-1:0] mhold[2], mlast[2], mframe[2];
    bit           e_bclk[2], e_lr[2], e_sd[2], e_und[2];
    int           e_k[2];
    int           acc_cnt = 0;

    task automatic mreset(int i);
        t[i] = 0; mfull[i] = 0; mhold[i] = '0; mlast[i] = '0; mframe[i] = '0;
        e_bclk[i] = 0; e_lr[i] = 1; e_sd[i] = 0; e_und[i] = 0; e_k[i] = 2 * sv[i] - 1;
    endtask

    task automatic mstep(int i);
        int d = dv[i];
        int s = sv[i];
        int n, p, q;
        bit cap = valid && !mfull[i];
        e_und[i] = 0;
        if ((t[i] + 1) % (2 * d) == 0) begin
            n = (t[i] + 1) / (2 * d);
            e_k[i] = (n - 1) % (2 * s);
            if (e_k[i] == 1) begin
                e_und[i] = !mfull[i];
                if (mfull[i]) mlast[i] = mhold[i];
                mframe[i] = mlast[i];
                mfull[i] = 0;
            end
            p = (e_k[i] + 2 * s - 1) % (2 * s);
            q = p % s;
            e_sd[i] = q < W ? mframe[i][W-1-q] : 1'b0;
            e_lr[i] = e_k[i] >= s;
        end
        if (cap) begin
            mfull[i] = 1;
            mhold[i] = data;
        end
        e_bclk[i] = ((t[i] + 1) / d) % 2 == 1;
        t[i]++;
    endtask

    always @(posedge clk) begin
        if (!rst && valid && a_rdy) acc_cnt++;
        for (int i = 0; i < 2; i++)
            if (rst) mreset(i); else mstep(i);
    end

    task automatic chk_inst(int i, logic bc, logic lr, logic sd, logic un, logic rd);
        string s = i == 0 ? "a" : "b";
        chk({s, "_bclk"}, bc, e_bclk[i]);
        chk({s, "_lrclk"}, lr, e_lr[i]);
        chk({s, "_sdata"}, sd, e_sd[i]);
        chk({s, "_underrun"}, un, e_und[i]);
        chk({s, "_ready"}, rd, !mfull[i]);
    endtask

    task automatic chk_reset(string s, logic bc, logic lr, logic sd, logic un, logic rd);
        chk({s, "_rst_vals"}, {bc, lr, sd, un, rd}, 32'b01001);
    endtask

    // Collect instance a's serial word as the DAC sees it on bclk rises, starting at k=1.
    int          rises = 0;
    int          und_cnt = 0;
    bit          prev = 0;
    logic [31:0] wsd, wlr;
    logic [31:0] fq[$], lq[$];

    always @(negedge clk) begin
        if (rst) begin
            rises = 0;
            prev = 0;
        end else begin
            chk_inst(0, a_bclk, a_lr, a_sd, a_und, a_rdy);
            chk_inst(1, b_bclk, b_lr, b_sd, b_und, b_rdy);
            if (a_und) und_cnt++;
            if (a_bclk && !prev) begin
                rises++;
                if (rises >= 3) begin
                    wsd = {wsd[30:0], a_sd};
                    wlr = {wlr[30:0], a_lr};
                    if ((rises - 3) % 32 == 31) begin
                        fq.push_back(wsd);
                        lq.push_back(wlr);
                    end
                end
            end
            prev = a_bclk;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("a", a_bclk, a_lr, a_sd, a_und, a_rdy);
        chk_reset("b", b_bclk, b_lr, b_sd, b_und, b_rdy);
        fq.delete();
        lq.delete();
        und_cnt = 0;
        acc_cnt = 0;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] qget(input logic [31:0] qq[$], input int idx);
        return qq.size() > idx ? qq[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic rand_cycles(int n);
        repeat (n) begin
            @(negedge clk);
            valid = $urandom_range(0, 3) == 0;
            data = W'($urandom);
        end
    endtask

    initial begin
        bit found;
        // Basic frame and handshake
        valid = 1'b1;
        data = 12'hA5C;
        do_reset();
        repeat (15) @(negedge clk);
        chk("ready_c14", a_rdy, 0);
        @(negedge clk);
        chk("ready_c15", a_rdy, 1);
        repeat (504) @(negedge clk);
        chk("accepts_520", acc_cnt, 3);
        chk("frame0_sd", qget(fq, 0), 32'hA5C0_A5C0);
        chk("frame0_lr", qget(lq, 0), 32'h0001_FFFE);

        // Underrun before and after a single sample
        valid = 1'b0;
        do_reset();
        repeat (300) @(negedge clk);
        chk("und_pre", und_cnt, 2);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (800) @(negedge clk);
        chk("und_total", und_cnt, 4);
        chk("und_f0", qget(fq, 0), 32'h0);
        chk("und_f1", qget(fq, 1), 32'h0);
        chk("und_f2", qget(fq, 2), 32'hA5C0_A5C0);
        chk("und_f3", qget(fq, 3), 32'hA5C0_A5C0);

        // Extreme values
        valid = 1'b1;
        data = 12'h800;
        do_reset();
        @(negedge clk);
        data = 12'h7FF;
        repeat (600) @(negedge clk);
        chk("neg_full", qget(fq, 0), 32'h8000_8000);
        chk("pos_full", qget(fq, 1), 32'h7FF0_7FF0);

        // Random traffic with an asynchronous reset at k=20
        do_reset();
        rand_cycles(1500);
        found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            valid = $urandom_range(0, 3) == 0;
            data = W'($urandom);
            found = e_k[0] == 20;
        end
        chk("k20_reached", found, 1);
        #2 rst = 1'b1;
        #1;
        chk_reset("a_async", a_bclk, a_lr, a_sd, a_und, a_rdy);
        chk_reset("b_async", b_bclk, b_lr, b_sd, b_und, b_rdy);
        do_reset();
        rand_cycles(1500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
